// File: rtl/image_buffer_ctrl_if.sv
// Bundle for the image buffer controller: pixel stream, BRAM write port,
// reader handshake and status flags.
interface image_buffer_ctrl_if #(
   parameter int unsigned PIXEL_SIZE = 8
);
   logic [PIXEL_SIZE-1:0] pixel_i;
   logic                  pixel_valid_i;
   logic                  pixel_ready_o;
   logic [31:0]           bram_wr_address;
   logic [31:0]           bram_wr_data;
   logic                  bram_wr_en;
   logic                  start_o;
   logic                  image_done_i;
   logic                  wr_slot_o;
   logic                  rd_slot_o;
   logic                  slots_full_o;
   logic                  protocol_err_o;

   // Controller side.
   modport slave (
      input  pixel_i, pixel_valid_i, image_done_i,
      output pixel_ready_o, bram_wr_address, bram_wr_data, bram_wr_en,
             start_o, wr_slot_o, rd_slot_o, slots_full_o, protocol_err_o
   );

   // Upstream source / reader / BRAM side.
   modport master (
      output pixel_i, pixel_valid_i, image_done_i,
      input  pixel_ready_o, bram_wr_address, bram_wr_data, bram_wr_en,
             start_o, wr_slot_o, rd_slot_o, slots_full_o, protocol_err_o
   );
endinterface

// File: rtl/image_buffer_ctrl.sv
// Ping-pong scheduler for a two-slot image BRAM: fills slots alternately from
// the pixel stream and hands complete images to the rotation reader in order.
module image_buffer_ctrl #(
   parameter int unsigned PIXEL_SIZE = 8,
   parameter int unsigned NUM_PIXELS = 784,
   parameter logic [31:0] BASE_ADDR1 = 32'hB000_0000,
   parameter logic [31:0] BASE_ADDR2 = 32'hB000_1000,
   parameter int unsigned ADDR_STEP  = 4
) (
   input  logic                clk,
   input  logic                reset,
   image_buffer_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      S_EMPTY   = 2'd0,
      S_FILLING = 2'd1,
      S_READY   = 2'd2,
      S_READING = 2'd3
   } slot_state_e;

   typedef enum logic [1:0] {
      R_IDLE  = 2'd0,
      R_START = 2'd1,
      R_BUSY  = 2'd2
   } rd_state_e;

   localparam logic [9:0]  LAST_IDX    = 10'(NUM_PIXELS - 1);
   localparam logic [31:0] ADDR_STEP_W = 32'(ADDR_STEP);

   slot_state_e status_q [2];
   slot_state_e status_d [2];
   rd_state_e   rd_state_q, rd_state_d;
   logic        wr_slot_q, wr_slot_d;
   logic        rd_slot_q, rd_slot_d;
   logic [9:0]  count_q, count_d;
   logic        err_q, err_d;
   logic        wr_en_q, wr_en_d;
   logic [31:0] wr_addr_q, wr_addr_d;
   logic [31:0] wr_data_q, wr_data_d;

   logic        pixel_ready;
   logic        accept;
   logic        start;
   logic        mark_reading;
   logic        mark_empty;
   slot_state_e wr_status;
   logic [31:0] slot_base;

   assign wr_status = status_q[wr_slot_q];
   assign slot_base = wr_slot_q ? BASE_ADDR2 : BASE_ADDR1;

   // Held low during reset so every output reads 0 while reset is asserted.
   assign pixel_ready = !reset && (wr_status == S_EMPTY || wr_status == S_FILLING);
   assign accept      = bus.pixel_valid_i && pixel_ready;

   // Read-side FSM: next state and Moore start pulse.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path can leave
      // it unassigned, which would otherwise infer a latch.
      rd_state_d   = rd_state_q;
      rd_slot_d    = rd_slot_q;
      start        = 1'b0;
      mark_reading = 1'b0;
      mark_empty   = 1'b0;
      err_d        = err_q;

      case (rd_state_q)
         R_IDLE: begin
            if (status_q[rd_slot_q] == S_READY) rd_state_d = R_START;
         end
         R_START: begin
            start        = 1'b1;
            mark_reading = 1'b1;
            rd_state_d   = R_BUSY;
         end
         R_BUSY: begin
            if (bus.image_done_i) begin
               mark_empty = 1'b1;
               rd_slot_d  = ~rd_slot_q;
               rd_state_d = R_IDLE;
            end
         end
         default: rd_state_d = R_IDLE;
      endcase

      if (bus.image_done_i && rd_state_q != R_BUSY) err_d = 1'b1;
   end

   // Write side and slot status; the writer and reader never own the same slot.
   always_comb begin
      status_d[0] = status_q[0];
      status_d[1] = status_q[1];
      count_d     = count_q;
      wr_slot_d   = wr_slot_q;
      wr_en_d     = accept;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;

      if (accept) begin
         wr_addr_d = slot_base + 32'(count_q) * ADDR_STEP_W;
         wr_data_d = 32'(bus.pixel_i);
         if (count_q == LAST_IDX) begin
            count_d             = '0;
            wr_slot_d           = ~wr_slot_q;
            status_d[wr_slot_q] = S_READY;
         end else begin
            count_d             = count_q + 10'd1;
            status_d[wr_slot_q] = S_FILLING;
         end
      end

      if (mark_reading) status_d[rd_slot_q] = S_READING;
      if (mark_empty)   status_d[rd_slot_q] = S_EMPTY;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         status_q[0] <= S_EMPTY;
         status_q[1] <= S_EMPTY;
         rd_state_q  <= R_IDLE;
         wr_slot_q   <= 1'b0;
         rd_slot_q   <= 1'b0;
         count_q     <= '0;
         err_q       <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the values
         // from before this edge, independent of statement order.
         status_q[0] <= status_d[0];
         status_q[1] <= status_d[1];
         rd_state_q  <= rd_state_d;
         wr_slot_q   <= wr_slot_d;
         rd_slot_q   <= rd_slot_d;
         count_q     <= count_d;
         err_q       <= err_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
      end
   end

   assign bus.pixel_ready_o   = pixel_ready;
   assign bus.bram_wr_en      = wr_en_q;
   assign bus.bram_wr_address = wr_addr_q;
   assign bus.bram_wr_data    = wr_data_q;
   assign bus.start_o         = start;
   assign bus.wr_slot_o       = wr_slot_q;
   assign bus.rd_slot_o       = rd_slot_q;
   assign bus.slots_full_o    = (status_q[0] == S_READY || status_q[0] == S_READING) &&
                                (status_q[1] == S_READY || status_q[1] == S_READING);
   assign bus.protocol_err_o  = err_q;

endmodule

// File: tb/tb_image_buffer_ctrl.sv
// Scoreboard bench for image_buffer_ctrl: expected BRAM writes and start pulses
// are queued by the stimulus and consumed by an independent monitor.
module tb_image_buffer_ctrl;

   localparam logic [31:0] B1 = 32'hB000_0000;
   localparam logic [31:0] B2 = 32'hB000_1000;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   image_buffer_ctrl_if #(.PIXEL_SIZE(8)) bus ();

   image_buffer_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct { logic [31:0] addr; logic [31:0] data; } wr_exp_t;
   typedef struct { logic slot; int cyc; } st_exp_t;

   wr_exp_t exp_wr [$];
   st_exp_t exp_st [$];

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops an expectation whenever the DUT writes or pulses start_o.
   always @(negedge clk) begin
      if (!reset && bus.bram_wr_en) begin
         if (exp_wr.size() == 0) begin
            check("unexpected_write", bus.bram_wr_address, 32'hFFFF_FFFF);
         end else begin
            wr_exp_t e;
            e = exp_wr.pop_front();
            check("wr_addr", bus.bram_wr_address, e.addr);
            check("wr_data", bus.bram_wr_data, e.data);
         end
      end
      if (!reset && bus.start_o) begin
         if (exp_st.size() == 0) begin
            check("unexpected_start", 32'(bus.rd_slot_o), 32'hFFFF_FFFF);
         end else begin
            st_exp_t s;
            s = exp_st.pop_front();
            check("start_slot", 32'(bus.rd_slot_o), 32'(s.slot));
            check("start_cycle", 32'(cyc), 32'(s.cyc));
         end
      end
   end

   // Streams n pixels of value (i*mul+add)%256 to a slot at base. Optionally
   // raises image_done_i alongside the final accepted pixel and queues the
   // start pulse expected two cycles after that final accept.
   task automatic send_image(input logic [31:0] base, input int n, input int mul,
                             input int add, input bit push_st, input bit st_slot,
                             input bit done_last, input int gap_at);
      logic [7:0] v;
      bit acc;
      @(posedge clk);
      #1;
      for (int i = 0; i < n; i++) begin
         if (i == gap_at) begin
            bus.pixel_valid_i = 1'b0;
            @(posedge clk);
            #1;
         end
         v = 8'(i * mul + add);
         bus.pixel_i       = v;
         bus.pixel_valid_i = 1'b1;
         acc = 1'b0;
         for (int w = 0; w < 40 && !acc; w++) begin
            @(negedge clk);
            if (bus.pixel_ready_o) begin
               acc = 1'b1;
               exp_wr.push_back('{base + 32'(i) * 32'd4, {24'd0, v}});
               if (i == n - 1) begin
                  if (done_last) bus.image_done_i = 1'b1;
                  if (push_st) exp_st.push_back('{st_slot, cyc + 2});
               end
            end
            @(posedge clk);
            #1;
            bus.image_done_i = 1'b0;
         end
         if (!acc) begin
            check("accept_timeout", 32'(i), 32'hFFFF_FFFF);
            bus.pixel_valid_i = 1'b0;
            return;
         end
      end
      bus.pixel_valid_i = 1'b0;
   endtask

   task automatic drain_start(input int lim);
      int k = 0;
      while (exp_st.size() != 0 && k < lim) begin
         @(negedge clk);
         k++;
      end
      check("start_seen", 32'(exp_st.size()), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ready"},  32'(bus.pixel_ready_o),  32'd0);
      check({tag, "_wr_en"},  32'(bus.bram_wr_en),     32'd0);
      check({tag, "_addr"},   bus.bram_wr_address,     32'd0);
      check({tag, "_data"},   bus.bram_wr_data,        32'd0);
      check({tag, "_start"},  32'(bus.start_o),        32'd0);
      check({tag, "_wrslot"}, 32'(bus.wr_slot_o),      32'd0);
      check({tag, "_rdslot"}, 32'(bus.rd_slot_o),      32'd0);
      check({tag, "_full"},   32'(bus.slots_full_o),   32'd0);
      check({tag, "_err"},    32'(bus.protocol_err_o), 32'd0);
   endtask

   initial begin
      bus.pixel_i       = '0;
      bus.pixel_valid_i = 1'b0;
      bus.image_done_i  = 1'b0;

      repeat (2) @(negedge clk);
      check_all_zero("reset");
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("ready_after_reset", 32'(bus.pixel_ready_o), 32'd1);

      // Image A into slot 0 with a one-cycle bubble; start two cycles after last accept.
      send_image(B1, 784, 1, 0, 1'b1, 1'b0, 1'b0, 300);
      @(negedge clk);
      check("a_wr_slot", 32'(bus.wr_slot_o), 32'd1);
      check("a_ready", 32'(bus.pixel_ready_o), 32'd1);
      drain_start(8);
      check("a_rd_slot", 32'(bus.rd_slot_o), 32'd0);

      // Image B into slot 1 while the reader still owns slot 0.
      send_image(B2, 784, 7, 3, 1'b0, 1'b0, 1'b0, -1);
      @(negedge clk);
      check("b_full", 32'(bus.slots_full_o), 32'd1);
      check("b_ready", 32'(bus.pixel_ready_o), 32'd0);
      check("b_wr_slot", 32'(bus.wr_slot_o), 32'd0);

      // First pixel of image C stalls until the reader frees slot 0.
      bus.pixel_i       = 8'hAA;
      bus.pixel_valid_i = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("c_stalled", 32'(bus.pixel_ready_o), 32'd0);
      end
      bus.image_done_i = 1'b1;
      exp_st.push_back('{1'b1, cyc + 2});
      @(posedge clk);
      #1;
      bus.image_done_i  = 1'b0;
      bus.pixel_valid_i = 1'b0;
      @(negedge clk);
      check("done_ready", 32'(bus.pixel_ready_o), 32'd1);
      check("done_full", 32'(bus.slots_full_o), 32'd0);
      drain_start(8);
      check("b_rd_slot", 32'(bus.rd_slot_o), 32'd1);

      // Image C into slot 0; its final pixel coincides with done for slot 1.
      send_image(B1, 784, 5, 17, 1'b1, 1'b0, 1'b1, -1);
      @(negedge clk);
      check("c_wr_slot", 32'(bus.wr_slot_o), 32'd1);
      check("c_ready", 32'(bus.pixel_ready_o), 32'd1);
      check("c_full", 32'(bus.slots_full_o), 32'd0);
      check("c_err", 32'(bus.protocol_err_o), 32'd0);
      drain_start(8);
      check("c_rd_slot", 32'(bus.rd_slot_o), 32'd0);

      // Legitimate done, then a stray done in R_IDLE.
      @(posedge clk);
      #1 bus.image_done_i = 1'b1;
      @(posedge clk);
      #1 bus.image_done_i = 1'b0;
      @(negedge clk);
      check("legit_done_err", 32'(bus.protocol_err_o), 32'd0);
      bus.image_done_i = 1'b1;
      @(posedge clk);
      #1 bus.image_done_i = 1'b0;
      @(negedge clk);
      check("stray_done_err", 32'(bus.protocol_err_o), 32'd1);
      check("stray_rd_slot", 32'(bus.rd_slot_o), 32'd1);
      check("stray_wr_slot", 32'(bus.wr_slot_o), 32'd1);
      check("stray_ready", 32'(bus.pixel_ready_o), 32'd1);
      repeat (5) @(negedge clk);
      check("err_sticky", 32'(bus.protocol_err_o), 32'd1);

      // Reset clears the error; then reset again part-way through slot 0.
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("reset_clears_err", 32'(bus.protocol_err_o), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      send_image(B1, 400, 1, 0, 1'b0, 1'b0, 1'b0, -1);
      @(negedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check_all_zero("midreset");
      @(posedge clk);
      #1 reset = 1'b0;
      send_image(B1, 784, 3, 1, 1'b1, 1'b0, 1'b0, -1);
      drain_start(8);
      check("final_rd_slot", 32'(bus.rd_slot_o), 32'd0);

      repeat (3) @(negedge clk);
      check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
      check("start_queue_empty", 32'(exp_st.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
